// File: rtl/book_req_arbiter_if.sv
// Update bus between the order-book message decoders and the book update port.
// The arbiter connects through the master modport; the requester/book side uses slave.
interface book_req_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 64
);
    localparam int SRC_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        reqValidIn;
    logic [NUM_REQ*DATA_W-1:0] reqDataIn;
    logic [NUM_REQ-1:0]        reqReadyOut;
    logic                      bookValidOut;
    logic [DATA_W-1:0]         bookDataOut;
    logic [SRC_W-1:0]          bookSrcOut;
    logic                      bookReadyIn;
    logic [15:0]               stallCntOut;

    modport master (
        input  reqValidIn, reqDataIn, bookReadyIn,
        output reqReadyOut, bookValidOut, bookDataOut, bookSrcOut, stallCntOut
    );

    modport slave (
        output reqValidIn, reqDataIn, bookReadyIn,
        input  reqReadyOut, bookValidOut, bookDataOut, bookSrcOut, stallCntOut
    );
endinterface

// File: rtl/book_req_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ decoder update streams into one
// registered, source-tagged book update port, with a saturating stall counter.
module book_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 64
) (
    input  logic               clk100In,
    input  logic               rstIn,
    book_req_arbiter_if.master bus
);
    localparam int               SRC_W     = $clog2(NUM_REQ);
    localparam logic [SRC_W-1:0] LAST_IDX  = SRC_W'(NUM_REQ - 1);
    localparam logic [15:0]      STALL_MAX = 16'hFFFF;

    logic                bookValidR;
    logic [DATA_W-1:0]   bookDataR;
    logic [SRC_W-1:0]    bookSrcR;
    logic [SRC_W-1:0]    ptrR;
    logic [15:0]         stallCntR;

    logic                stageFreeS;
    logic                hiFoundS;
    logic                anyValidS;
    logic [SRC_W-1:0]    hiIdxS;
    logic [SRC_W-1:0]    loIdxS;
    logic [SRC_W-1:0]    candIdxS;
    logic [SRC_W-1:0]    ptrNextS;
    logic                grantS;
    logic                stallS;
    logic [NUM_REQ-1:0]  reqReadyS;
    logic [DATA_W-1:0]   candDataS;

    // Candidate search: lowest valid index at or above ptr, otherwise lowest valid index (wrap).
    always_comb begin
        hiFoundS  = 1'b0;
        anyValidS = 1'b0;
        hiIdxS    = '0;
        loIdxS    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            anyValidS = anyValidS | bus.reqValidIn[i];
            loIdxS    = bus.reqValidIn[i] ? SRC_W'(i) : loIdxS;
            hiFoundS  = hiFoundS | (bus.reqValidIn[i] && (SRC_W'(i) >= ptrR));
            hiIdxS    = (bus.reqValidIn[i] && (SRC_W'(i) >= ptrR)) ? SRC_W'(i) : hiIdxS;
        end
        candIdxS = hiFoundS ? hiIdxS : loIdxS;
    end

    // Grant decision and ready vector; the ready path never looks at the data words.
    always_comb begin
        stageFreeS = !bookValidR || bus.bookReadyIn;
        grantS     = anyValidS && stageFreeS && !rstIn;
        reqReadyS  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            reqReadyS[i] = grantS && (candIdxS == SRC_W'(i));
        end
        stallS   = |(bus.reqValidIn & ~reqReadyS);
        ptrNextS = (candIdxS == LAST_IDX) ? '0 : candIdxS + SRC_W'(1'b1);
    end

    // Word mux for the candidate requester.
    always_comb begin
        candDataS = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            candDataS = (candIdxS == SRC_W'(i)) ? bus.reqDataIn[i*DATA_W +: DATA_W] : candDataS;
        end
    end

    // Output stage and round-robin pointer; a consumed word with no replacement only clears valid.
    always_ff @(posedge clk100In) begin
        if (rstIn) begin
            bookValidR <= 1'b0;
            bookDataR  <= '0;
            bookSrcR   <= '0;
            ptrR       <= '0;
        end else if (grantS) begin
            bookValidR <= 1'b1;
            bookDataR  <= candDataS;
            bookSrcR   <= candIdxS;
            ptrR       <= ptrNextS;
        end else if (bus.bookReadyIn) begin
            bookValidR <= 1'b0;
        end
    end

    // Stall counter: one count per cycle in which any valid requester is left waiting.
    always_ff @(posedge clk100In) begin
        if (rstIn) begin
            stallCntR <= 16'd0;
        end else if (stallS && (stallCntR != STALL_MAX)) begin
            stallCntR <= stallCntR + 16'd1;
        end
    end

    assign bus.reqReadyOut  = reqReadyS;
    assign bus.bookValidOut = bookValidR;
    assign bus.bookDataOut  = bookDataR;
    assign bus.bookSrcOut   = bookSrcR;
    assign bus.stallCntOut  = stallCntR;
endmodule

// File: tb/tb_book_req_arbiter.sv
// Bench for book_req_arbiter: randomized and directed stimulus, reference model
// with an expected-word queue drained by an independent output monitor.
module tb_book_req_arbiter;
    localparam int N  = 4;
    localparam int DW = 64;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic rst;
    logic rst3;
    always #5 clk = ~clk;

    book_req_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus4 ();
    book_req_arbiter #(.NUM_REQ(N), .DATA_W(DW)) dut4 (.clk100In(clk), .rstIn(rst), .bus(bus4));

    book_req_arbiter_if #(.NUM_REQ(3), .DATA_W(8)) bus3 ();
    book_req_arbiter #(.NUM_REQ(3), .DATA_W(8)) dut3 (.clk100In(clk), .rstIn(rst3), .bus(bus3));

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit                 pendValid [N];
    logic [DW-1:0]      pendData  [N];
    bit                 mOutValid;
    int                 mPtr;
    int                 mStall;
    logic [DW+SW-1:0]   expQ [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic setReq(input int i, input logic [DW-1:0] d);
        pendValid[i] = 1'b1;
        pendData[i]  = d;
    endtask

    // One clock cycle: drive at posedge+1, check and advance the model after the negedge.
    task automatic stepCycle(input bit r, input bit rdy, input logic [N-1:0] newMask);
        logic [N-1:0] expReady;
        int g;
        bit stalled;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (!pendValid[i] && newMask[i]) setReq(i, {$urandom, $urandom});
        end
        rst = r;
        bus4.bookReadyIn = rdy;
        for (int i = 0; i < N; i++) begin
            bus4.reqValidIn[i]           = pendValid[i];
            bus4.reqDataIn[i*DW +: DW]   = pendData[i];
        end
        @(negedge clk);
        #1;
        expReady = '0;
        g = -1;
        if (!r && (!mOutValid || rdy)) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && pendValid[(mPtr + k) % N]) g = (mPtr + k) % N;
            end
        end
        if (g >= 0) expReady[g] = 1'b1;
        chk("reqReady", 64'(bus4.reqReadyOut), 64'(expReady));
        chk("bookValid", 64'(bus4.bookValidOut), 64'(mOutValid));
        chk("stallCnt", 64'(bus4.stallCntOut), 64'(mStall));
        stalled = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (pendValid[i] && i != g) stalled = 1'b1;
        end
        if (r) begin
            mOutValid = 1'b0;
            mPtr      = 0;
            mStall    = 0;
            expQ.delete();
        end else begin
            if (g >= 0) begin
                expQ.push_back({SW'(g), pendData[g]});
                mOutValid    = 1'b1;
                mPtr         = (g + 1) % N;
                pendValid[g] = 1'b0;
            end else if (rdy) begin
                mOutValid = 1'b0;
            end
            if (stalled && mStall < 65535) mStall++;
        end
    endtask

    task automatic doReset();
        for (int i = 0; i < N; i++) pendValid[i] = 1'b0;
        stepCycle(1'b1, 1'b1, '0);
    endtask

    task automatic step3(input logic [2:0] v, input bit r, output logic [2:0] rdyObs);
        @(posedge clk);
        #1;
        rst3 = r;
        bus3.reqValidIn = v;
        @(negedge clk);
        #1;
        rdyObs = bus3.reqReadyOut;
    endtask

    // Output monitor: every presented word must match the oldest expected grant.
    initial begin
        forever begin
            @(negedge clk);
            if (bus4.bookValidOut === 1'b1) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpectedWord actual src=%0d data=0x%0h required=none",
                             bus4.bookSrcOut, bus4.bookDataOut);
                end else begin
                    chk("bookSrc", 64'(bus4.bookSrcOut), 64'(expQ[0][DW +: SW]));
                    chk("bookData", bus4.bookDataOut, expQ[0][DW-1:0]);
                    if (bus4.bookReadyIn && !rst) void'(expQ.pop_front());
                end
            end
        end
    end

    // Watchdog
    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] r3;
        rst = 1'b1;
        rst3 = 1'b1;
        bus4.reqValidIn  = '0;
        bus4.reqDataIn   = '0;
        bus4.bookReadyIn = 1'b0;
        bus3.reqValidIn  = 3'b000;
        bus3.reqDataIn   = {8'hA2, 8'hA1, 8'hA0};
        bus3.bookReadyIn = 1'b1;
        for (int i = 0; i < N; i++) begin
            pendValid[i] = 1'b0;
            pendData[i]  = '0;
        end
        mOutValid = 1'b0;
        mPtr = 0;
        mStall = 0;
        repeat (2) @(posedge clk);

        // Reset state, ready forced low while requests are pending in reset
        stepCycle(1'b1, 1'b1, 4'hF);
        chk("rstReady", 64'(bus4.reqReadyOut), 64'd0);
        chk("rstData", bus4.bookDataOut, 64'd0);
        chk("rstSrc", 64'(bus4.bookSrcOut), 64'd0);
        doReset();

        // Single requester
        setReq(2, 64'hA5);
        stepCycle(1'b0, 1'b1, '0);
        chk("singleReady", 64'(bus4.reqReadyOut), 64'b0100);
        stepCycle(1'b0, 1'b0, '0);
        chk("singleValid", 64'(bus4.bookValidOut), 64'd1);
        chk("singleData", bus4.bookDataOut, 64'hA5);
        chk("singleSrc", 64'(bus4.bookSrcOut), 64'd2);
        setReq(0, 64'h100);
        setReq(3, 64'h103);
        stepCycle(1'b0, 1'b1, '0);
        chk("ptrAfterSingle", 64'(bus4.reqReadyOut), 64'b1000);
        repeat (3) stepCycle(1'b0, 1'b1, '0);

        // Fairness: all continuously valid
        doReset();
        for (int k = 1; k <= 9; k++) begin
            stepCycle(1'b0, 1'b1, (k <= 8) ? 4'hF : 4'h0);
            if (k >= 2) chk("rotSrc", 64'(bus4.bookSrcOut), 64'((k - 2) % 4));
        end
        chk("rotStall", 64'(bus4.stallCntOut), 64'd8);

        // Backpressure
        doReset();
        setReq(0, 64'h11);
        stepCycle(1'b0, 1'b1, '0);
        setReq(1, 64'hBEEF_0001);
        for (int k = 0; k < 5; k++) begin
            stepCycle(1'b0, 1'b0, '0);
            chk("bpReady", 64'(bus4.reqReadyOut), 64'd0);
            chk("bpHold", bus4.bookDataOut, 64'h11);
        end
        stepCycle(1'b0, 1'b1, '0);
        chk("bpRelease", 64'(bus4.reqReadyOut), 64'b0010);
        chk("bpStall", 64'(bus4.stallCntOut), 64'd5);
        stepCycle(1'b0, 1'b0, '0);
        chk("bpNewData", bus4.bookDataOut, 64'hBEEF_0001);
        chk("bpNewSrc", 64'(bus4.bookSrcOut), 64'd1);
        stepCycle(1'b0, 1'b1, '0);

        // Reset mid-operation
        doReset();
        setReq(2, 64'h77);
        stepCycle(1'b0, 1'b1, '0);
        setReq(1, 64'h201);
        stepCycle(1'b0, 1'b0, '0);
        chk("midHold", bus4.bookDataOut, 64'h77);
        stepCycle(1'b1, 1'b0, '0);
        chk("midRstReady", 64'(bus4.reqReadyOut), 64'd0);
        setReq(3, 64'h203);
        setReq(0, 64'h200);
        stepCycle(1'b0, 1'b1, '0);
        chk("postRstValid", 64'(bus4.bookValidOut), 64'd0);
        chk("postRstSrc", 64'(bus4.bookSrcOut), 64'd0);
        chk("postRstStall", 64'(bus4.stallCntOut), 64'd0);
        chk("postRstGrant", 64'(bus4.reqReadyOut), 64'b0001);
        repeat (4) stepCycle(1'b0, 1'b1, '0);

        // Stall counter saturation
        doReset();
        setReq(0, 64'h300);
        stepCycle(1'b0, 1'b1, '0);
        setReq(0, 64'h301);
        repeat (65600) stepCycle(1'b0, 1'b0, '0);
        chk("satStall", 64'(bus4.stallCntOut), 64'hFFFF);
        repeat (3) stepCycle(1'b0, 1'b0, '0);
        chk("satHold", 64'(bus4.stallCntOut), 64'hFFFF);
        doReset();

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            stepCycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7),
                      4'($urandom_range(0, 15) & $urandom_range(0, 15)));
        end
        doReset();

        // Non-power-of-2 wrap and skip on the 3-requester instance
        step3(3'b000, 1'b1, r3);
        step3(3'b010, 1'b0, r3);
        chk("w3Grant1", 64'(r3), 64'b010);
        step3(3'b001, 1'b0, r3);
        chk("w3SkipWrap", 64'(r3), 64'b001);
        chk("w3Src1", 64'(bus3.bookSrcOut), 64'd1);
        step3(3'b100, 1'b0, r3);
        chk("w3Grant2", 64'(r3), 64'b100);
        chk("w3Data0", 64'(bus3.bookDataOut), 64'hA0);
        step3(3'b011, 1'b0, r3);
        chk("w3PtrWrap", 64'(r3), 64'b001);
        chk("w3Src2", 64'(bus3.bookSrcOut), 64'd2);
        chk("w3Data2", 64'(bus3.bookDataOut), 64'hA2);
        step3(3'b010, 1'b0, r3);
        chk("w3Next", 64'(r3), 64'b010);
        chk("w3Valid", 64'(bus3.bookValidOut), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/book_req_arbiter.md
# book_req_arbiter

Round-robin arbiter sharing the single order-book update port between NUM_REQ message decoders (e.g. add, cancel, execute, replace) in the clk100 domain, downstream of the Ethernet RX clock-domain crossing. Each requester presents one update word per valid/ready handshake. The arbiter picks one per cycle, registers it into a single output stage tagged with the source index, and holds it until the book accepts it. A saturating stall counter exposes contention for debug.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 64, update word width
- SRC_W, $clog2(NUM_REQ), width of source tag (derived, not overridden)
- clk100In  input  1  100 MHz system clock; all logic on rising edge
- rstIn  input  1  reset, synchronous, active-high
- reqValidIn  input  NUM_REQ  per-requester valid
- reqDataIn  input  NUM_REQ*DATA_W  packed words; requester i at bits [i*DATA_W +: DATA_W]
- reqReadyOut  output  NUM_REQ  per-requester ready (one-hot or zero)
- bookValidOut  output  1  output word valid
- bookDataOut  output  DATA_W  granted word
- bookSrcOut  output  SRC_W  index of requester that supplied bookDataOut
- bookReadyIn  input  1  book accepts the output word
- stallCntOut  output  16  saturating count of requester-stall cycles

## Operation
- Output stage free when `!bookValidOut || bookReadyIn`.
- Round-robin pointer ptr (SRC_W bits): search order ptr, ptr+1, …, wrapping modulo NUM_REQ. The first requester with reqValidIn set is the candidate.
- reqReadyOut[cand] = output stage free; all other bits 0. reqReadyOut is combinational from reqValidIn, ptr, bookValidOut, and bookReadyIn. It must not depend combinationally on reqDataIn.
- Accept on a cycle where reqValidIn[i] && reqReadyOut[i]:
  - bookDataOut <= word i
  - bookSrcOut <= i
  - bookValidOut <= 1
  - ptr <= (i+1) mod NUM_REQ; wrap from NUM_REQ-1 to 0 is explicit and correct for non-power-of-2 NUM_REQ.
- Output consumed with no new accept (bookReadyIn=1, no candidate): bookValidOut <= 0. bookDataOut and bookSrcOut keep their last value.
- Output held (bookValidOut=1, bookReadyIn=0): bookValidOut, bookDataOut, and bookSrcOut are stable, and all reqReadyOut are 0.
- Simultaneous consume and accept: the new word replaces the old in the same edge, with no bubble.
- No valid requesters: ptr unchanged.
- Requester rules (not checked by arbiter): once reqValidIn[i] is asserted, it stays asserted with stable data until accepted. An arbiter without a pending grant need not record unaccepted requests.
- stallCntOut increments by 1 on each cycle where at least one reqValidIn bit is set and no accept occurs for it.
  - "Stall cycles" counts cycles, not requesters.
  - Saturates at 16'hFFFF; never wraps.
- Reset (rstIn=1 at an edge):
  - bookValidOut=0, bookDataOut=0, bookSrcOut=0, ptr=0, stallCntOut=0.
  - reqReadyOut is forced to 0 while rstIn=1.
  - A word pending in the output stage is dropped, and nothing is accepted in a reset cycle.

## Timing
- Latency: accept edge to bookValidOut=1 is 1 cycle.
- Throughput: one word per cycle while bookReadyIn=1.
- Fairness: with all NUM_REQ requesters continuously valid and bookReadyIn=1, grants rotate 0,1,…,NUM_REQ-1,0. Any continuously valid requester waits at most NUM_REQ-1 accepts of others.
- bookReadyIn low for N cycles stalls all requesters for N cycles; the output word is unchanged.
- First cycle after rstIn deasserts: accepts are allowed, starting from requester 0.

## Test plan
- Single requester, NUM_REQ=4: req 2 sends 0xA5 with bookReadyIn=1 → reqReadyOut=4'b0100 in the same cycle; next cycle bookValidOut=1, bookDataOut=0xA5, bookSrcOut=2; ptr=3.
- All four valid continuously, bookReadyIn=1, 8 cycles → bookSrcOut sequence 0,1,2,3,0,1,2,3 on consecutive cycles with no bubbles; stallCntOut=8 (others wait each cycle).
- Backpressure: output holds 0x11 and bookReadyIn=0 for 5 cycles with req 1 valid → reqReadyOut=0; bookDataOut stays 0x11; stallCntOut +5. On bookReadyIn=1, req 1 is accepted in that cycle and bookDataOut=req1 word the next cycle.
- Wrap and skip, NUM_REQ=3 (non-power-of-2): ptr=2, only req 0 valid → req 0 granted; ptr becomes 1; then only req 2 valid → granted; ptr wraps to 0.
- Saturation: force 70000 stall cycles (bookReadyIn=0, req 0 valid) → stallCntOut reads 16'hFFFF and stays there.
- Reset mid-operation: output valid holding 0x77 and ptr=3, assert rstIn for one cycle → bookValidOut=0, bookSrcOut=0, stallCntOut=0, reqReadyOut=0 during reset. After release, with req 3 and req 0 valid, req 0 is granted first.
